// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundle of every signal crossing the ID/EX pipeline boundary.
//   Decode side : id_valid, id_ready, id_rs, id_rt, id_rd, id_uses_rt,
//                 id_rd1, id_rd2, id_imm, id_pc4, id_ctrl
//   Control     : flush (branch taken in EX), hold (MEM stall)
//   Execute side: ex_valid, ex_rs, ex_rt, ex_dest, ex_a, ex_b, ex_imm,
//                 ex_pc4, ex_ctrl
//   Status      : stall, stall_cnt, flush_cnt
// id_ctrl / ex_ctrl layout: {reg_write, mem_read, mem_write, reg_dst,
//                            alu_src, alu_op[2:0]}
// master = surrounding pipeline, slave = the ID/EX stage itself.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_ready;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic             id_uses_rt;
    logic [DW-1:0]    id_rd1;
    logic [DW-1:0]    id_rd2;
    logic [DW-1:0]    id_imm;
    logic [DW-1:0]    id_pc4;
    logic [7:0]       id_ctrl;
    logic             flush;
    logic             hold;
    logic             ex_valid;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic [4:0]       ex_dest;
    logic [DW-1:0]    ex_a;
    logic [DW-1:0]    ex_b;
    logic [DW-1:0]    ex_imm;
    logic [DW-1:0]    ex_pc4;
    logic [7:0]       ex_ctrl;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_uses_rt,
               id_rd1, id_rd2, id_imm, id_pc4, id_ctrl, flush, hold,
        input  id_ready, ex_valid, ex_rs, ex_rt, ex_dest, ex_a, ex_b,
               ex_imm, ex_pc4, ex_ctrl, stall, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rt,
               id_rd1, id_rd2, id_imm, id_pc4, id_ctrl, flush, hold,
        output id_ready, ex_valid, ex_rs, ex_rt, ex_dest, ex_a, ex_b,
               ex_imm, ex_pc4, ex_ctrl, stall, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute pipeline register of the 5-stage MIPS core. Captures
// operands, decoded fields and control bits, inserts a bubble on a load-use
// hazard against the instruction in EX, honours branch flush and MEM hold,
// and keeps saturating stall/flush event counters.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset, clears every register
//   bus   - id_ex_stage_if slave modport (decode inputs, flush/hold,
//           EX register outputs, stall and counters)
// Per-edge action priority: hold > flush > load-use bubble > advance.
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    localparam int CTRL_MEM_READ = 6;
    localparam int CTRL_REG_DST  = 4;

    logic             ex_valid_q;
    logic [4:0]       ex_rs_q;
    logic [4:0]       ex_rt_q;
    logic [4:0]       ex_dest_q;
    logic [DW-1:0]    ex_a_q;
    logic [DW-1:0]    ex_b_q;
    logic [DW-1:0]    ex_imm_q;
    logic [DW-1:0]    ex_pc4_q;
    logic [7:0]       ex_ctrl_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic hazard;
    logic dest_hits;

    // A load in EX whose destination is a source of the decode instruction
    // cannot be forwarded in time; r0 is never a real dependency.
    assign dest_hits = (ex_dest_q == bus.id_rs) |
                       (bus.id_uses_rt & (ex_dest_q == bus.id_rt));
    assign hazard    = bus.id_valid & ex_valid_q & ex_ctrl_q[CTRL_MEM_READ] &
                       (ex_dest_q != 5'd0) & dest_hits;

    // Flush consumes (and discards) the decode instruction, a bubble makes
    // decode re-present it, hold freezes everything.
    assign bus.id_ready = ~bus.hold & (bus.flush | ~hazard);
    assign bus.stall    = ~bus.hold & ~bus.flush & hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_dest_q   <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_imm_q    <= '0;
            ex_pc4_q    <= '0;
            ex_ctrl_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (bus.hold) begin
            // Freeze: a pending flush is re-asserted by upstream later.
        end else if (bus.flush || hazard) begin
            ex_valid_q <= 1'b0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_dest_q  <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
            ex_pc4_q   <= '0;
            ex_ctrl_q  <= '0;
            if (bus.flush) begin
                if (flush_cnt_q != {CNT_W{1'b1}})
                    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end else begin
                if (stall_cnt_q != {CNT_W{1'b1}})
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_valid_q <= bus.id_valid;
            ex_rs_q    <= bus.id_rs;
            ex_rt_q    <= bus.id_rt;
            ex_dest_q  <= bus.id_ctrl[CTRL_REG_DST] ? bus.id_rd : bus.id_rt;
            ex_a_q     <= bus.id_rd1;
            ex_b_q     <= bus.id_rd2;
            ex_imm_q   <= bus.id_imm;
            ex_pc4_q   <= bus.id_pc4;
            // An invalid slot must never write registers or memory.
            ex_ctrl_q  <= bus.id_valid ? bus.id_ctrl : 8'd0;
        end
    end

    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_rs     = ex_rs_q;
    assign bus.ex_rt     = ex_rt_q;
    assign bus.ex_dest   = ex_dest_q;
    assign bus.ex_a      = ex_a_q;
    assign bus.ex_b      = ex_b_q;
    assign bus.ex_imm    = ex_imm_q;
    assign bus.ex_pc4    = ex_pc4_q;
    assign bus.ex_ctrl   = ex_ctrl_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed-vector bench for id_ex_stage. Each applied vector pushes its
// hand-computed expectation (combinational id_ready/stall for that cycle
// plus the EX register contents after the edge) into a queue; a monitor
// pops and compares. Counters are instantiated 8 bits wide so saturation
// is reachable in a few hundred cycles.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DW    = 32;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        uses_rt;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [7:0]  ctrl;
        logic        flush;
        logic        hold;
    } vec_t;

    typedef struct packed {
        logic        ready;
        logic        stall;
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [7:0]  ctrl;
        logic [7:0]  scnt;
        logic [7:0]  fcnt;
    } exp_t;

    // ctrl: add = 8'h92, lw = 8'hC8 (dest = rt), addi = 8'h88 (dest = rt)
    localparam vec_t V_ADD   = '{1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 32'h11, 32'h22, 32'h33, 32'h104, 8'h92, 1'b0, 1'b0};
    localparam vec_t V_LW    = '{1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 32'h1000, 32'h0, 32'h10, 32'h108, 8'hC8, 1'b0, 1'b0};
    localparam vec_t V_USE   = '{1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 32'h5, 32'h6, 32'h0, 32'h10C, 8'h92, 1'b0, 1'b0};
    localparam vec_t V_ADDI  = '{1'b1, 5'd2, 5'd8, 5'd0, 1'b0, 32'h7, 32'h8, 32'h4, 32'h110, 8'h88, 1'b0, 1'b0};
    localparam vec_t V_LW0   = '{1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 32'h2000, 32'h0, 32'h0, 32'h114, 8'hC8, 1'b0, 1'b0};
    localparam vec_t V_ADD0  = '{1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 32'h0, 32'h0, 32'h0, 32'h118, 8'h92, 1'b0, 1'b0};
    localparam vec_t V_USERT = '{1'b1, 5'd2, 5'd8, 5'd10, 1'b1, 32'h7, 32'h8, 32'h0, 32'h11C, 8'h92, 1'b0, 1'b0};
    localparam vec_t V_IDLE  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0, 1'b1};

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    id_ex_stage_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.id_valid   = v.valid;
        bus.id_rs      = v.rs;
        bus.id_rt      = v.rt;
        bus.id_rd      = v.rd;
        bus.id_uses_rt = v.uses_rt;
        bus.id_rd1     = v.rd1;
        bus.id_rd2     = v.rd2;
        bus.id_imm     = v.imm;
        bus.id_pc4     = v.pc4;
        bus.id_ctrl    = v.ctrl;
        bus.flush      = v.flush;
        bus.hold       = v.hold;
    endtask

    // One cycle of stimulus: drive on the falling edge, queue its expectation.
    task automatic apply_stimulus(input vec_t v, input exp_t e);
        @(negedge clk);
        drive(v);
        exp_q.push_back(e);
    endtask

    // Freeze the stage with hold and let the monitor finish outstanding work.
    task automatic drain();
        @(negedge clk);
        drive(V_IDLE);
        repeat (3) @(negedge clk);
    endtask

    function automatic exp_t bubble(input logic r, input logic st, input logic [7:0] s, input logic [7:0] f);
        bubble = '{r, st, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00, s, f};
    endfunction

    function automatic vec_t with_ctl(input vec_t v, input logic fl, input logic hd, input logic vld);
        with_ctl       = v;
        with_ctl.flush = fl;
        with_ctl.hold  = hd;
        with_ctl.valid = vld;
    endfunction

    // Monitor: comb outputs of the newest vector are compared 2 ns after the
    // falling edge it was driven on; its register effects one cycle later.
    initial begin
        exp_t cur;
        bit   have_cur;
        have_cur = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (have_cur) begin
                check_output("ex_valid",  32'(bus.ex_valid),  32'(cur.valid));
                check_output("ex_rs",     32'(bus.ex_rs),     32'(cur.rs));
                check_output("ex_rt",     32'(bus.ex_rt),     32'(cur.rt));
                check_output("ex_dest",   32'(bus.ex_dest),   32'(cur.dest));
                check_output("ex_a",      bus.ex_a,           cur.a);
                check_output("ex_b",      bus.ex_b,           cur.b);
                check_output("ex_imm",    bus.ex_imm,         cur.imm);
                check_output("ex_pc4",    bus.ex_pc4,         cur.pc4);
                check_output("ex_ctrl",   32'(bus.ex_ctrl),   32'(cur.ctrl));
                check_output("stall_cnt", 32'(bus.stall_cnt), 32'(cur.scnt));
                check_output("flush_cnt", 32'(bus.flush_cnt), 32'(cur.fcnt));
                have_cur = 1'b0;
            end
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check_output("id_ready", 32'(bus.id_ready), 32'(cur.ready));
                check_output("stall",    32'(bus.stall),    32'(cur.stall));
                have_cur = 1'b1;
            end
        end
    end

    initial begin
        logic [7:0] s;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(V_IDLE);
        repeat (2) @(negedge clk);
        #1;
        check_output("rst ex_valid",  32'(bus.ex_valid),  32'h0);
        check_output("rst ex_a",      bus.ex_a,           32'h0);
        check_output("rst ex_dest",   32'(bus.ex_dest),   32'h0);
        check_output("rst ex_ctrl",   32'(bus.ex_ctrl),   32'h0);
        check_output("rst stall_cnt", 32'(bus.stall_cnt), 32'h0);
        check_output("rst flush_cnt", 32'(bus.flush_cnt), 32'h0);
        check_output("rst stall",     32'(bus.stall),     32'h0);
        rst_n = 1'b1;

        // Straight-line advance, then load followed by dependent add.
        apply_stimulus(V_ADD,   '{1'b1, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, 32'h104, 8'h92, 8'd0, 8'd0});
        apply_stimulus(V_LW,    '{1'b1, 1'b0, 1'b1, 5'd1, 5'd8, 5'd8, 32'h1000, 32'h0, 32'h10, 32'h108, 8'hC8, 8'd0, 8'd0});
        apply_stimulus(V_USE,   bubble(1'b0, 1'b1, 8'd1, 8'd0));
        apply_stimulus(V_USE,   '{1'b1, 1'b0, 1'b1, 5'd8, 5'd9, 5'd10, 32'h5, 32'h6, 32'h0, 32'h10C, 8'h92, 8'd1, 8'd0});

        // Hazard filters: rt not used, and a load targeting r0.
        apply_stimulus(V_LW,    '{1'b1, 1'b0, 1'b1, 5'd1, 5'd8, 5'd8, 32'h1000, 32'h0, 32'h10, 32'h108, 8'hC8, 8'd1, 8'd0});
        apply_stimulus(V_ADDI,  '{1'b1, 1'b0, 1'b1, 5'd2, 5'd8, 5'd8, 32'h7, 32'h8, 32'h4, 32'h110, 8'h88, 8'd1, 8'd0});
        apply_stimulus(V_LW0,   '{1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 32'h2000, 32'h0, 32'h0, 32'h114, 8'hC8, 8'd1, 8'd0});
        apply_stimulus(V_ADD0,  '{1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 32'h118, 8'h92, 8'd1, 8'd0});

        // Flush beats a simultaneous hazard.
        apply_stimulus(V_LW,    '{1'b1, 1'b0, 1'b1, 5'd1, 5'd8, 5'd8, 32'h1000, 32'h0, 32'h10, 32'h108, 8'hC8, 8'd1, 8'd0});
        apply_stimulus(with_ctl(V_USE, 1'b1, 1'b0, 1'b1), bubble(1'b1, 1'b0, 8'd1, 8'd1));

        // Hold for three cycles with flush and new data present.
        apply_stimulus(V_ADD,   '{1'b1, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, 32'h104, 8'h92, 8'd1, 8'd1});
        for (int i = 0; i < 3; i++)
            apply_stimulus(with_ctl(V_ADDI, 1'b1, 1'b1, 1'b1),
                           '{1'b0, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, 32'h104, 8'h92, 8'd1, 8'd1});
        apply_stimulus(with_ctl(V_ADDI, 1'b1, 1'b0, 1'b1), bubble(1'b1, 1'b0, 8'd1, 8'd2));

        // Invalid slot: payload loads, control forced to zero.
        apply_stimulus(with_ctl(V_ADD, 1'b0, 1'b0, 1'b0),
                       '{1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, 32'h104, 8'h00, 8'd1, 8'd2});

        // Load-use through rt.
        apply_stimulus(V_LW,    '{1'b1, 1'b0, 1'b1, 5'd1, 5'd8, 5'd8, 32'h1000, 32'h0, 32'h10, 32'h108, 8'hC8, 8'd1, 8'd2});
        apply_stimulus(V_USERT, bubble(1'b0, 1'b1, 8'd2, 8'd2));
        apply_stimulus(V_USERT, '{1'b1, 1'b0, 1'b1, 5'd2, 5'd8, 5'd10, 32'h7, 32'h8, 32'h0, 32'h11C, 8'h92, 8'd2, 8'd2});

        // 2^CNT_W + 3 further hazard cycles drive stall_cnt into saturation.
        s = 8'd2;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            apply_stimulus(V_LW, '{1'b1, 1'b0, 1'b1, 5'd1, 5'd8, 5'd8, 32'h1000, 32'h0, 32'h10, 32'h108, 8'hC8, s, 8'd2});
            if (s != 8'hFF) s = s + 8'd1;
            apply_stimulus(V_USE, bubble(1'b0, 1'b1, s, 8'd2));
        end
        apply_stimulus(V_ADD,   '{1'b1, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, 32'h104, 8'h92, 8'hFF, 8'd2});
        drain();
        check_output("sat stall_cnt", 32'(bus.stall_cnt), 32'hFF);

        // Asynchronous reset pulse between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        check_output("async ex_valid",  32'(bus.ex_valid),  32'h0);
        check_output("async ex_a",      bus.ex_a,           32'h0);
        check_output("async ex_pc4",    bus.ex_pc4,         32'h0);
        check_output("async ex_dest",   32'(bus.ex_dest),   32'h0);
        check_output("async ex_ctrl",   32'(bus.ex_ctrl),   32'h0);
        check_output("async stall_cnt", 32'(bus.stall_cnt), 32'h0);
        check_output("async flush_cnt", 32'(bus.flush_cnt), 32'h0);
        rst_n = 1'b1;

        // Normal priority resumes after reset.
        apply_stimulus(V_ADD,   '{1'b1, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, 32'h104, 8'h92, 8'd0, 8'd0});
        apply_stimulus(V_LW,    '{1'b1, 1'b0, 1'b1, 5'd1, 5'd8, 5'd8, 32'h1000, 32'h0, 32'h10, 32'h108, 8'hC8, 8'd0, 8'd0});
        apply_stimulus(V_USE,   bubble(1'b0, 1'b1, 8'd1, 8'd0));
        drain();

        check_output("queue empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
